// File: rtl/rr_prio_enc.sv
// ============================================================================
// Module   : rr_prio_enc
// Brief    : Registered N-line priority encoder with valid/ack handshake.
//            Define RR_PRIO_ENC_ROUND_ROBIN_EN for round-robin arbitration;
//            otherwise the highest set request index wins.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_prio_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  logic [0:0]   state;
  logic         any_req;
  logic [W-1:0] win;
  logic [N-1:0] win_oh;

  assign any_req = |req;
  assign valid   = (state == S_GRANT);

`ifdef RR_PRIO_ENC_ROUND_ROBIN_EN
  logic [W-1:0]   ptr;
  logic [W-1:0]   idx_inc;
  logic [W-1:0]   base;
  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [W:0]     sum;
  logic           found;

  // Wrap explicitly so non-power-of-two N never yields an index >= N.
  assign idx_inc = (idx == W'(N - 1)) ? '0 : idx + W'(1);
  // A back-to-back grant must already see the pointer advanced past idx.
  assign base    = (state == S_GRANT) ? idx_inc : ptr;
  assign req2    = {req, req};

  always_comb begin
    rot   = N'(req2 >> base);
    win   = '0;
    sum   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, base} + (W+1)'(k);
        if (sum >= (W+1)'(N)) begin
          sum = sum - (W+1)'(N);
        end
        win = sum[W-1:0];
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        win = W'(i);
      end
    end
  end
`endif

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < N; i++) begin
      win_oh[i] = (win == W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      idx   <= '0;
      grant <= '0;
`ifdef RR_PRIO_ENC_ROUND_ROBIN_EN
      ptr   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state <= S_GRANT;
            idx   <= win;
            grant <= win_oh;
          end
        end
        S_GRANT: begin
          if (ack) begin
`ifdef RR_PRIO_ENC_ROUND_ROBIN_EN
            ptr <= idx_inc;
`endif
            if (any_req) begin
              idx   <= win;
              grant <= win_oh;
            end else begin
              state <= S_IDLE;
              grant <= '0;
            end
          end
        end
        default: begin
          state <= S_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_prio_enc.sv
// Testbench for rr_prio_enc: reference model feeds a scoreboard queue, with
// directed checks for hold, drain, wrap (N=5) and reset-during-grant.
`default_nettype none

module tb_rr_prio_enc;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       ack;
  logic       valid;
  logic [1:0] idx;
  logic [3:0] grant;
  logic [4:0] req5;
  logic       valid5;
  logic [2:0] idx5;
  logic [4:0] grant5;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rr_prio_enc #(.N(4), .W(2)) u4 (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .valid(valid), .idx(idx), .grant(grant)
  );

  rr_prio_enc #(.N(5), .W(3)) u5 (
    .clk(clk), .rst(rst), .req(req5), .ack(ack),
    .valid(valid5), .idx(idx5), .grant(grant5)
  );

  typedef struct packed {
    logic       v;
    logic [1:0] i;
    logic [3:0] g;
  } exp_t;

  exp_t q[$];

  // Reference model state for the N=4 instance.
  logic m_v = 1'b0;
  int   m_i = 0;
  int   m_p = 0;

  function automatic int win4(input logic [3:0] rq, input int p);
    int r;
    r = 0;
`ifdef RR_PRIO_ENC_ROUND_ROBIN_EN
    for (int k = 3; k >= 0; k--) begin
      if (((rq >> ((p + k) % 4)) & 4'd1) != 4'd0) r = (p + k) % 4;
    end
`else
    for (int k = 0; k < 4; k++) begin
      if (((rq >> k) & 4'd1) != 4'd0) r = k;
    end
`endif
    return r;
  endfunction

  task automatic model(input logic r, input logic [3:0] rq, input logic a);
    exp_t e;
    if (r) begin
      m_v = 1'b0; m_i = 0; m_p = 0;
    end else if (!m_v) begin
      if (rq != 4'd0) begin
        m_v = 1'b1; m_i = win4(rq, m_p);
      end
    end else if (a) begin
`ifdef RR_PRIO_ENC_ROUND_ROBIN_EN
      m_p = (m_i + 1) % 4;
`endif
      if (rq != 4'd0) m_i = win4(rq, m_p);
      else m_v = 1'b0;
    end
    e.v = m_v;
    e.i = m_i[1:0];
    e.g = m_v ? (4'd1 << m_i) : 4'd0;
    q.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle, record the model's expectation, then compare after the edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic a, input logic [4:0] rq5);
    exp_t e;
    rst = r; req = rq; ack = a; req5 = rq5;
    model(r, rq, a);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      n_cmp++; n_bad++;
      $error("FAIL scoreboard: observed empty queue expected entry");
    end else begin
      e = q.pop_front();
      chk("sb_valid", {7'd0, valid}, {7'd0, e.v});
      chk("sb_idx",   {6'd0, idx},   {6'd0, e.i});
      chk("sb_grant", {4'd0, grant}, {4'd0, e.g});
    end
  endtask

  logic [2:0] exp5 [4];

  initial begin
    rst = 1'b1; req = 4'd0; ack = 1'b0; req5 = 5'd0;
    @(negedge clk);

    // Reset with requests pending
    step(1'b1, 4'b1111, 1'b0, 5'd0);
    step(1'b1, 4'b1111, 1'b0, 5'd0);
    chk("rst_valid", {7'd0, valid}, 8'd0);
    chk("rst_idx",   {6'd0, idx},   8'd0);
    chk("rst_grant", {4'd0, grant}, 8'd0);
    step(1'b0, 4'b1111, 1'b0, 5'd0);
    chk("post_rst_valid", {7'd0, valid}, 8'd1);

    // Accept, then hold while req changes
    step(1'b0, 4'b0101, 1'b1, 5'd0);
    chk("hold_idx0", {6'd0, idx}, 8'd2);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 4'b0001, 1'b0, 5'd0);
      chk("hold_idx",   {6'd0, idx},   8'd2);
      chk("hold_grant", {4'd0, grant}, 8'b0100);
    end
    step(1'b0, 4'b0001, 1'b1, 5'd0);
    chk("ack_idx",   {6'd0, idx},   8'd0);
    chk("ack_grant", {4'd0, grant}, 8'b0001);

    // Drain
    step(1'b0, 4'b0010, 1'b1, 5'd0);
    chk("drain_idx", {6'd0, idx}, 8'd1);
    step(1'b0, 4'b0000, 1'b1, 5'd0);
    chk("drain_valid", {7'd0, valid}, 8'd0);
    chk("drain_grant", {4'd0, grant}, 8'd0);
    chk("drain_idx_hold", {6'd0, idx}, 8'd1);
    step(1'b0, 4'b0000, 1'b1, 5'd0);
    chk("idle_ack_valid", {7'd0, valid}, 8'd0);

    // Continuous rotation (round-robin) / fixed top index
    for (int k = 0; k < 6; k++) step(1'b0, 4'b1111, 1'b1, 5'd0);
    chk("rot_last_idx", {6'd0, idx}, 8'd3);

    // Reset while granting with ack high
    step(1'b1, 4'b1111, 1'b1, 5'd0);
    chk("midrst_valid", {7'd0, valid}, 8'd0);
    chk("midrst_idx",   {6'd0, idx},   8'd0);
    step(1'b0, 4'b1111, 1'b1, 5'd0);
`ifdef RR_PRIO_ENC_ROUND_ROBIN_EN
    chk("midrst_first", {6'd0, idx}, 8'd0);
`else
    chk("midrst_first", {6'd0, idx}, 8'd3);
`endif

    // N=5 wrap
`ifdef RR_PRIO_ENC_ROUND_ROBIN_EN
    exp5[0] = 3'd0; exp5[1] = 3'd4; exp5[2] = 3'd0; exp5[3] = 3'd4;
`else
    exp5[0] = 3'd4; exp5[1] = 3'd4; exp5[2] = 3'd4; exp5[3] = 3'd4;
`endif
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 4'b0000, 1'b1, 5'b10001);
      chk("n5_valid", {7'd0, valid5}, 8'd1);
      chk("n5_idx",   {5'd0, idx5},   {5'd0, exp5[k]});
      chk("n5_grant", {3'd0, grant5}, 8'd1 << exp5[k]);
    end

    // Random traffic against the model
    for (int k = 0; k < 60; k++) begin
      step(($urandom_range(0, 29) == 0), 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      chk("n5_range", {7'd0, (idx5 < 3'd5)}, 8'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rr_prio_enc.md
# rr_prio_enc

Parametrised, registered priority encoder with a valid/ack handshake. It generalises the fixed 4-to-2 case encoder to N request lines and a log2 index output. A winner is held stable until the consumer acknowledges it. Arbitration is either fixed-priority or round-robin, selected at compile time. It sits between request sources (interrupt lines, channel requesters) and a single consumer that services one index at a time.

## Interface
Parameters:
- N, 4, number of request lines (N ≥ 2; need not be a power of two).
- W, 2, index width; must equal ceil(log2(N)).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector, sampled every clk edge; bit i = requester i.
- ack  input  1  consumer accepts the current grant; meaningful only when valid=1.
- valid  output  1  registered; a grant is presented.
- idx  output  W  registered; binary index of the granted requester.
- grant  output  N  registered; one-hot form of idx; all zero when valid=0.

## Operation
- Two states:
  - IDLE: valid=0.
  - GRANT: valid=1; idx and grant are frozen.
- IDLE, |req=1 → GRANT. idx and grant are loaded with the winner of the current req.
- IDLE, req=0 → stay in IDLE.
- GRANT, ack=0 → stay in GRANT. Outputs hold even if req changes or the granted bit drops (grants are sticky).
- GRANT, ack=1, |req=1 → stay in GRANT and load a new winner, giving back-to-back grants. The new arbitration uses the current req and the updated priority pointer.
- GRANT, ack=1, req=0 → IDLE. valid=0, grant=0, and idx keeps its last value.
- Winner selection, fixed mode: the highest set index wins.
- Winner selection, round-robin mode:
  - The search runs upward from pointer p (p, p+1, …, N-1, 0, …, p-1). The first set bit wins.
  - On each accepted grant (valid && ack), p ← (idx+1) mod N. The wrap is from N-1 to 0, including non-power-of-two N.
  - In IDLE, p is unchanged.
- grant is always the one-hot decode of idx while valid=1.

## Timing
- Reset: the next clk edge with rst=1 forces valid=0, idx=0, grant=0, p=0 and state IDLE. This applies mid-grant as well; an ack in the same cycle is ignored.
- Latency: req sampled at edge t gives valid/idx/grant at edge t+1. No combinational path exists from req or ack to any output.
- Throughput: one grant per cycle when ack is held at 1 and requests persist.
- ack with valid=0 is ignored.

## Configuration
- Macro RR_PRIO_ENC_ROUND_ROBIN_EN.
- Defined: round-robin selection with pointer p, as described above.
- Undefined: fixed priority (highest index wins). p is not implemented and is not updated.
- Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Reset: rst=1 for 2 cycles while req=1111 → valid=0, idx=0, grant=0000. After release, valid=1 one cycle later.
- Fixed, hold: macro off, N=4, req=0101, ack=0 → valid=1, idx=2, grant=0100. Change req to 0001 for 3 cycles → outputs unchanged. Pulse ack → next cycle idx=0, grant=0001.
- Round-robin rotation: macro on, N=4, req=1111, ack=1 continuously → idx sequence 0,1,2,3,0,1 on consecutive cycles, with valid steady at 1.
- Drain: macro on, single request req=0010 then req=0000, ack=1 → one cycle valid=1 with idx=1, then valid=0 and grant=0000, with idx held at 1.
- Wrap with non-power-of-two N: macro on, N=5, W=3, req=10001, ack=1 → idx 0, 4, 0, 4. Confirm p wraps from 4 to 0 and no index ≥5 ever appears.
- Reset mid-grant: valid=1, idx=3, assert rst together with ack=1 → next cycle valid=0, idx=0. After release with req=1111 and the macro on, the first grant is idx=0.
